multi_prio_disp: RTL
====================

MULTI_PRIO_DISP -- requirements
Module: multi_prio_disp

Interface
REQ-001 Parameter W, default 12: request vector width, legal range 1..15.
REQ-002 Parameter N, default 18: refresh counter width, minimum 4; each digit is lit for 2^(N-2) cycles.
REQ-003 clk  in  1: single clock; all state changes on the rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 r  in  W: request vector; bit i set means request of priority i+1 (bit W-1 highest).
REQ-006 start  in  1: capture-and-scan request, sampled each cycle.
REQ-007 busy  out  1: high while a scan is in progress.
REQ-008 done  out  1: one-cycle pulse when new results are published.
REQ-009 ranks  out  16: four 4-bit rank codes; rank k in [4k+3:4k]; code = bit index+1, 0 = none.
REQ-010 count  out  3: number of nonzero rank codes published, 0..4.
REQ-011 an  out  4: digit enables, active-low, exactly one low at a time.
REQ-012 sseg  out  8: segments, active-low, {dp,g,f,e,d,c,b,a}.

Function
REQ-013 FSM states: IDLE, SCAN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> latch r into a mask register, clear scan index and scratch ranks, go to SCAN; start=0 -> stay in IDLE.
REQ-015 SCAN lasts exactly 4 cycles; in scan cycle k (0..3), scratch rank k = (index of highest set mask bit)+1 and that bit is cleared; if the mask is zero, scratch rank k = 0.
REQ-016 After scan cycle 3 -> DONE; DONE -> IDLE unconditionally after one cycle.
REQ-017 Latency: start sampled in cycle t; busy=1 in cycles t+1..t+4; done=1 in cycle t+5 only.
REQ-018 ranks and count are shadow registers, updated only on the edge that raises done, and held otherwise; ranks is valid in the same cycle as done.
REQ-019 start is ignored in SCAN and DONE; changes on r after capture do not affect the scan in progress.
REQ-020 count equals popcount(r) saturated at 4, using r as captured.
REQ-021 Refresh: a free-running N-bit counter wraps from 2^N-1 to 0.
REQ-022 Digit select: d = counter[N-1:N-2]; an[d] is driven low.
REQ-023 Digit d displays rank (3-d), so rank0 (highest priority) is on the leftmost digit, an[3].
REQ-024 Rank code 0 blanks its digit: sseg = 8'hFF.
REQ-025 Codes 1..15 are shown as hex digits 1..F in standard 7-segment glyphs, with dp off (bit 7 = 1).
REQ-026 an and sseg are registered, one cycle behind the counter; the display path runs independently of the FSM.

Reset
REQ-027 The following values apply in the cycle after reset=1:
- state IDLE
- busy=0, done=0
- ranks=16'h0000, count=0
- mask and scratch registers zero
- refresh counter 0, an=4'b1110, sseg=8'hFF
REQ-028 Reset asserted during SCAN or DONE aborts the scan: no done pulse occurs and the published ranks become zero.
REQ-029 Reset takes priority over start in the same cycle.

Verification
REQ-030 r=12'h804, start pulse -> busy for 4 cycles, done at t+5, ranks=16'h003C (rank0=12, rank1=3), count=2.
REQ-031 r=12'h000, start -> done at t+5, ranks=16'h0000, count=0, sseg=8'hFF on all digits.
REQ-032 r=12'hFFF, start -> ranks=16'h9ABC, count=4; r changed to 0 during SCAN -> same result.
REQ-033 Start with r=12'h001 held, then second start with r=12'h800 in cycle t+2 -> second start ignored, ranks=16'h0001, count=1.
REQ-034 Reset asserted in cycle t+3 of a scan -> busy=0 in the next cycle, no done pulse, ranks=0.
REQ-035 Display path, N=4, ranks=16'h003C:
- an sequence 1110,1101,1011,0111, each held 4 cycles, then repeats
- sseg=8'hC6 ("C") while an=0111, 8'hB0 ("3") while an=1011, 8'hFF otherwise

Source files
------------

// File: rtl/multi_prio_disp.sv
// rtl/multi_prio_disp.sv - four-deep priority ranker with multiplexed 7-segment readout
//
// Purpose: on start, captures a request vector and ranks the four highest set
// bits (one per cycle), publishes the rank codes and their count, and shows the
// ranks on a 4-digit common-anode display that is refreshed independently.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high
//   r      in   W   request vector, bit W-1 is highest priority
//   start  in   1   capture r and begin a scan (honoured only when idle)
//   busy   out  1   scan in progress
//   done   out  1   one-cycle pulse when ranks/count are published
//   ranks  out  16  rank k in [4k+3:4k], code = bit index + 1, 0 = none
//   count  out  3   number of nonzero rank codes
//   an     out  4   digit enables, active-low
//   sseg   out  8   segments {dp,g,f,e,d,c,b,a}, active-low
module multi_prio_disp #(
  parameter int W = 12,
  parameter int N = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] r,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [15:0]  ranks,
  output logic [2:0]   count,
  output logic [3:0]   an,
  output logic [7:0]   sseg
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mask_q, mask_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    scratch_q, scratch_d;
  logic [15:0]    ranks_q, ranks_d;
  logic [2:0]     count_q, count_d;
  logic [N-1:0]   refresh_q;
  logic [3:0]     an_q;
  logic [7:0]     sseg_q;

  logic [3:0]     hi_code;
  logic [W-1:0]   hi_onehot;
  logic [1:0]     dsel;
  logic [3:0]     disp_code;

  // Ascending loop: the last set bit seen is the highest one.
  always_comb begin
    hi_code   = 4'd0;
    hi_onehot = '0;
    for (int i = 0; i < W; i++) begin
      if (mask_q[i]) begin
        hi_code      = 4'(i + 1);
        hi_onehot    = '0;
        hi_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    scratch_d = scratch_q;
    ranks_d   = ranks_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d    = r;
          idx_d     = 2'd0;
          scratch_d = 16'h0000;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        scratch_d[{idx_q, 2'b00} +: 4] = hi_code;
        mask_d = mask_q & ~hi_onehot;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          // Publish including the rank being written this cycle.
          ranks_d = scratch_d;
          count_d = 3'd0;
          for (int k = 0; k < 4; k++) begin
            if (scratch_d[4*k +: 4] != 4'd0) begin
              count_d = count_d + 3'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      idx_q     <= 2'd0;
      scratch_q <= 16'h0000;
      ranks_q   <= 16'h0000;
      count_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      scratch_q <= scratch_d;
      ranks_q   <= ranks_d;
      count_q   <= count_d;
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      4'hF: glyph = 8'h8E;
      default: glyph = 8'hFF;  // code 0 blanks the digit
    endcase
  endfunction

  // Digit d shows rank 3-d, i.e. rank index ~d, so rank0 lands on an[3].
  assign dsel      = refresh_q[N-1:N-2];
  assign disp_code = ranks_q[{~dsel, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      an_q      <= 4'b1110;
      sseg_q    <= 8'hFF;
    end else begin
      refresh_q <= refresh_q + N'(1);
      an_q      <= ~(4'b0001 << dsel);
      sseg_q    <= glyph(disp_code);
    end
  end

  assign busy  = (state_q == SCAN);
  assign done  = (state_q == DONE);
  assign ranks = ranks_q;
  assign count = count_q;
  assign an    = an_q;
  assign sseg  = sseg_q;

endmodule
